// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the round-robin memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int PERF_COUNT_WIDTH = 16;

  // Successor of a port index in round-robin order, wrapping to port 0.
  function automatic int next_rr_index(input int index, input int num_ports);
    return (index >= num_ports - 1) ? 0 : index + 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side bundle of mem_arbiter; slave is the arbiter, master
// is the environment (requesters plus memory macro).
interface mem_arbiter_if #(
    parameter int NumPorts        = 2,
    parameter int WordSize        = 32,
    parameter int WordsNumberLog2 = 8
);
    logic [NumPorts-1:0]                 ReqValid;
    logic [NumPorts-1:0]                 ReqWrite;
    logic [NumPorts*WordsNumberLog2-1:0] ReqAddress;
    logic [NumPorts*WordSize-1:0]        ReqData;
    logic [NumPorts-1:0]                 Done;
    logic [WordSize-1:0]                 RespData;
    logic                                Busy;
    logic                                MemStatus;
    logic [WordsNumberLog2-1:0]          MemAddress;
    logic [WordSize-1:0]                 MemI;
    logic [WordSize-1:0]                 MemQ;

    modport slave (
        input  ReqValid, ReqWrite, ReqAddress, ReqData, MemQ,
        output Done, RespData, Busy, MemStatus, MemAddress, MemI
    );

    modport master (
        output ReqValid, ReqWrite, ReqAddress, ReqData, MemQ,
        input  Done, RespData, Busy, MemStatus, MemAddress, MemI
    );
endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible port after LastGrant, wrapping.
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int NumPorts = 2,
    localparam int IdxW    = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic [NumPorts-1:0] Eligible,
    input  logic [IdxW-1:0]     LastGrant,
    output logic                Found,
    output logic [IdxW-1:0]     Index
);

    int candidate;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        Found     = 1'b0;
        Index     = '0;
        candidate = int'(LastGrant);
        for (int k = 0; k < NumPorts; k++) begin
            candidate = next_rr_index(candidate, NumPorts);
            if (!Found && Eligible[candidate]) begin
                Found = 1'b1;
                Index = IdxW'(candidate);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NumPorts requesters.
// Optional per-port grant counters (GrantCount) when MEM_ARB_PERF_EN is defined.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NumPorts        = 2,
    parameter int WordSize        = 32,
    parameter int WordsNumberLog2 = 8
) (
    input  logic Clock,
    input  logic ResetN,
    mem_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [NumPorts*PERF_COUNT_WIDTH-1:0] GrantCount
`endif
);

    localparam int IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    state_t                     State;
    logic [IdxW-1:0]            Grant;
    logic [IdxW-1:0]            LastGrant;
    logic [WordsNumberLog2-1:0] SelAddress;
    logic [WordSize-1:0]        SelData;
    logic                       SelWrite;
    logic [NumPorts-1:0]        DoneReg;
    logic [WordSize-1:0]        RespReg;

    logic [NumPorts-1:0]        Eligible;
    logic                       Found;
    logic [IdxW-1:0]            PickIndex;

    // A port completing this cycle is masked so it cannot be granted twice in a row
    // on the strength of a request it has not yet had a chance to renew.
    assign Eligible = bus.ReqValid & ~DoneReg;

    rr_picker #(
        .NumPorts (NumPorts)
    ) u_picker (
        .Eligible  (Eligible),
        .LastGrant (LastGrant),
        .Found     (Found),
        .Index     (PickIndex)
    );

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            State      <= IDLE;
            Grant      <= '0;
            LastGrant  <= IdxW'(NumPorts - 1);
            SelAddress <= '0;
            SelData    <= '0;
            SelWrite   <= 1'b0;
            DoneReg    <= '0;
            RespReg    <= '0;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            DoneReg <= '0;
            case (State)
                IDLE: begin
                    if (Found) begin
                        SelAddress <= bus.ReqAddress[int'(PickIndex)*WordsNumberLog2 +: WordsNumberLog2];
                        SelData    <= bus.ReqData[int'(PickIndex)*WordSize +: WordSize];
                        SelWrite   <= bus.ReqWrite[PickIndex];
                        Grant      <= PickIndex;
                        State      <= ACCESS;
                    end
                end
                ACCESS: begin
                    DoneReg[Grant] <= 1'b1;
                    if (!SelWrite) begin
                        RespReg <= bus.MemQ;
                    end
                    LastGrant <= Grant;
                    State     <= IDLE;
                end
                default: State <= IDLE;
            endcase
        end
    end

    // Status is decoded from the state register so an async reset drops it at once.
    assign bus.Busy       = (State == ACCESS);
    assign bus.MemStatus  = (State == ACCESS) && SelWrite;
    assign bus.MemAddress = SelAddress;
    assign bus.MemI       = SelData;
    assign bus.Done       = DoneReg;
    assign bus.RespData   = RespReg;

`ifdef MEM_ARB_PERF_EN
    logic [NumPorts-1:0][PERF_COUNT_WIDTH-1:0] PerfCount;

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            PerfCount <= '0;
        end else begin
            for (int i = 0; i < NumPorts; i++) begin
                if (DoneReg[i] && (PerfCount[i] != '1)) begin
                    PerfCount[i] <= PerfCount[i] + 1'b1;
                end
            end
        end
    end

    assign GrantCount = PerfCount;
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-port word memory (async read, write on posedge Clock when Status=1) between NumPorts requesters, e.g. instruction fetch and load/store.
- Accepts valid/done requests, serialises them into one memory access each, and returns read data.
- Sits between the core's fetch/LSU units and the memory macro.

Parameters:
- NumPorts, 2, number of requesters (≥2).
- WordSize, 32, data word width.
- WordsNumberLog2, 8, memory address width.

Ports:
- Clock  in  1  system clock; all state on posedge.
- ResetN  in  1  asynchronous, active-low reset.
- ReqValid  in  NumPorts  per-port request valid.
- ReqWrite  in  NumPorts  per-port 1=write, 0=read.
- ReqAddress  in  NumPorts*WordsNumberLog2  packed addresses; port i at [i*W +: W].
- ReqData  in  NumPorts*WordSize  packed write data.
- Done  out  NumPorts  one-cycle completion pulse per port.
- RespData  out  WordSize  read data of the last completed read (broadcast).
- Busy  out  1  high while in ACCESS.
- MemStatus  out  1  memory Status (1 = write).
- MemAddress  out  WordsNumberLog2  memory address.
- MemI  out  WordSize  memory write data.
- MemQ  in  WordSize  memory read data (combinational from MemAddress).

Behaviour:
- Reset (async, ResetN=0): State=IDLE, Done=0, RespData=0, LastGrant=NumPorts-1 (port 0 wins first), latched addr/data/write=0. MemStatus=0 immediately.
- Handshake: requester raises ReqValid[i] with payload and holds all of them stable until it sees Done[i]=1. It may drop ReqValid or present a new request in the Done cycle. Payload changes before Done are illegal.
- IDLE:
  - Eligible set = ReqValid & ~Done, so a port that is completing this cycle is masked.
  - If the set is non-empty, pick the first eligible port searching from (LastGrant+1) mod NumPorts upward, with wrap-around.
  - Latch that port's addr/data/write into Sel*, set Grant=index, go to ACCESS.
  - If the set is empty, stay in IDLE.
- ACCESS (exactly one cycle):
  - MemAddress=SelAddress, MemI=SelData, MemStatus=SelWrite. The write commits at the closing edge.
  - At the closing edge: Done[Grant]<=1; if read, RespData<=MemQ; LastGrant<=Grant; go to IDLE.
- Outside ACCESS: MemStatus=0. MemAddress/MemI hold the Sel values (no spurious writes).
- Timing:
  - Latency: request sampled in cycle t → ACCESS in t+1 → Done and RespData valid in t+2.
  - Peak throughput: one access every 2 cycles.
- Done is high for exactly one cycle and is cleared in every cycle it was not set.
- RespData holds its value until the next read completes; writes leave it unchanged.
- Simultaneous requests: round-robin guarantees no port waits more than NumPorts-1 grants.
- Reset asserted during ACCESS: the FSM returns to IDLE asynchronously, MemStatus drops, the pending write is abandoned, and no Done is issued.
- Busy = (State==ACCESS).

Optional Feature:
- MEM_ARB_PERF_EN defined:
  - Adds output GrantCount [NumPorts*16]: per-port 16-bit grant counters.
  - A port's counter increments on each Done pulse, saturates at 0xFFFF, and resets to 0.
- Undefined: the port and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg:
  - state enum {IDLE, ACCESS};
  - PERF_COUNT_WIDTH=16;
  - function next_rr_index.
- Sub-module rr_picker: combinational; inputs eligible mask and LastGrant, outputs Found and index.
- FSM, payload latches and counters stay in mem_arbiter.

Test Plan:
- Single read: memory[0x10]=0xDEADBEEF; port 0 reads 0x10 at cycle 0 → Done[0] at cycle 2, RespData=0xDEADBEEF, MemStatus never 1.
- Write then read: port 1 writes 0xCAFEF00D to 0x3F, then reads 0x3F → MemStatus=1 only in its ACCESS cycle; read returns 0xCAFEF00D.
- Contention: ports 0 and 1 hold valid continuously from reset → grant order 0,1,0,1; Done alternates every 2 cycles; RespData unchanged by writes.
- Back-to-back same port: port 0 issues a new request in its Done cycle → it is masked in that cycle; port 1, if also pending, wins next; no double grant of port 0.
- Reset mid-op: ResetN=0 during a write ACCESS → MemStatus=0 at once; target word keeps its old value; Done stays 0; after release port 0 has priority.
- With MEM_ARB_PERF_EN: 3 grants to port 0 and 2 to port 1 → GrantCount = {16'd2, 16'd3}; force 0xFFFF and grant again → stays 0xFFFF.
